// File: rtl/sec32_share_arbiter_if.sv
// rtl/sec32_share_arbiter_if.sv - request/response bus between memory-read clients and the shared SEC decode arbiter
interface sec32_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ*8-1:0]  req_check;
  logic [NREQ-1:0]    req_chk_en;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_data;
  logic [IDX_W-1:0]   rsp_id;
  logic               rsp_corrected;

  modport master (
    output req_valid, req_data, req_check, req_chk_en, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_corrected
  );

  modport slave (
    input  req_valid, req_data, req_check, req_chk_en, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_corrected
  );
endinterface

// File: rtl/sec32_share_arbiter.sv
// rtl/sec32_share_arbiter.sv - round-robin share of one SEC decode datapath with operand and response stages
module sec32_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sec32_share_arbiter_if.slave bus,
  output logic [31:0]          dp_id_o,
  output logic [7:0]           dp_ic_o,
  output logic                 dp_r_o,
  input  logic [31:0]          dp_od_i,
  input  logic                 clr_count_i,
  output logic [CNT_W-1:0]     corr_count_o
);

  logic [IDX_W-1:0] rr_q, rr_d;
  logic             s1_vld_q, s1_vld_d;
  logic [31:0]      s1_data_q, s1_data_d;
  logic [7:0]       s1_check_q, s1_check_d;
  logic             s1_en_q, s1_en_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic             s2_vld_q, s2_vld_d;
  logic [31:0]      s2_data_q, s2_data_d;
  logic [IDX_W-1:0] s2_id_q, s2_id_d;
  logic             s2_corr_q, s2_corr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx, cand;
  logic [31:0]      sel_data;
  logic [7:0]       sel_check;
  logic             sel_en;
  logic             s2_free, s1_adv, s1_open, accept, corr_next;

  // Round-robin search: the smallest offset from rr_q wins, so offsets are scanned high to low
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_q) + k) % NREQ);
      if (bus.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Select the granted requester's word, check byte and check enable
  always_comb begin
    sel_data  = '0;
    sel_check = '0;
    sel_en    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == IDX_W'(k)) begin
        sel_data  = bus.req_data[k*32 +: 32];
        sel_check = bus.req_check[k*8 +: 8];
        sel_en    = bus.req_chk_en[k];
      end
    end
  end

  assign s2_free   = ~s2_vld_q | bus.rsp_ready;
  assign s1_adv    = s1_vld_q & s2_free;
  assign s1_open   = ~s1_vld_q | s1_adv;
  assign accept    = grant_vld & s1_open;
  assign corr_next = (dp_od_i != dp_id_o);

  assign bus.req_ready     = accept ? (NREQ'(1) << grant_idx) : '0;
  assign dp_id_o           = s1_vld_q ? s1_data_q  : 32'h0;
  assign dp_ic_o           = s1_vld_q ? s1_check_q : 8'h0;
  assign dp_r_o            = s1_vld_q & s1_en_q;
  assign bus.rsp_valid     = s2_vld_q;
  assign bus.rsp_data      = s2_data_q;
  assign bus.rsp_id        = s2_id_q;
  assign bus.rsp_corrected = s2_corr_q;
  assign corr_count_o      = cnt_q;

  // Next state of both stages, the rr pointer and the saturating counter
  always_comb begin
    rr_d       = rr_q;
    s1_data_d  = s1_data_q;
    s1_check_d = s1_check_q;
    s1_en_d    = s1_en_q;
    s1_idx_d   = s1_idx_q;
    s2_data_d  = s2_data_q;
    s2_id_d    = s2_id_q;
    s2_corr_d  = s2_corr_q;
    cnt_d      = cnt_q;
    s1_vld_d   = accept | (s1_vld_q & ~s1_adv);
    s2_vld_d   = s1_adv | (s2_vld_q & ~bus.rsp_ready);
    if (accept) begin
      s1_data_d  = sel_data;
      s1_check_d = sel_check;
      s1_en_d    = sel_en;
      s1_idx_d   = grant_idx;
      rr_d       = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
    if (s1_adv) begin
      s2_data_d = dp_od_i;
      s2_id_d   = s1_idx_q;
      s2_corr_d = corr_next;
    end
    if (clr_count_i) begin
      cnt_d = '0;
    end else if (s1_adv && corr_next && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset drops any in-flight request without a response
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= '0;
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      s1_check_q <= '0;
      s1_en_q    <= 1'b0;
      s1_idx_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_data_q  <= '0;
      s2_id_q    <= '0;
      s2_corr_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rr_q       <= rr_d;
      s1_vld_q   <= s1_vld_d;
      s1_data_q  <= s1_data_d;
      s1_check_q <= s1_check_d;
      s1_en_q    <= s1_en_d;
      s1_idx_q   <= s1_idx_d;
      s2_vld_q   <= s2_vld_d;
      s2_data_q  <= s2_data_d;
      s2_id_q    <= s2_id_d;
      s2_corr_q  <= s2_corr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sec32_share_arbiter.sv
// tb/tb_sec32_share_arbiter.sv - self-checking bench for sec32_share_arbiter
module tb_sec32_share_arbiter;
  localparam int NREQ  = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_count;
  logic [31:0] dp_id, dp_od;
  logic [7:0]  dp_ic;
  logic        dp_r;
  logic [CNT_W-1:0] corr_count;
  int pass_cnt = 0;
  int total_cnt = 0;

  sec32_share_arbiter_if #(.NREQ(NREQ), .IDX_W(IDX_W)) bus ();

  sec32_share_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dp_id_o(dp_id), .dp_ic_o(dp_ic), .dp_r_o(dp_r), .dp_od_i(dp_od),
    .clr_count_i(clr_count), .corr_count_o(corr_count)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared decoder: clears the lowest set data bit, folds in the check byte when enabled
  function automatic logic [31:0] dp_fn(input logic [31:0] id, input logic [7:0] ic, input logic r);
    return (id & (id - 32'd1)) ^ (r ? {24'h0, ic} : 32'h0);
  endfunction

  assign dp_od = dp_fn(dp_id, dp_ic, dp_r);

  // Reference model: in-flight requests in arrival order, each aged by cycles since acceptance
  typedef struct {
    logic [31:0] data;
    logic [7:0]  chk;
    logic        en;
    int          idx;
    int          age;
    bit          counted;
  } item_t;

  item_t pipe[$];
  int m_rr = 0;
  int m_cnt = 0;

  function automatic int m_grant();
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit m_open();
    return (pipe.size() < 2) || bus.rsp_ready;
  endfunction

  function automatic logic [NREQ-1:0] m_ready();
    int g;
    g = m_grant();
    if (g >= 0 && m_open()) return NREQ'(1) << g;
    return '0;
  endfunction

  function automatic bit m_rsp_valid();
    return (pipe.size() > 0) && (pipe[0].age >= 1);
  endfunction

  function automatic logic [31:0] m_dp_id();
    if (pipe.size() == 2) return pipe[1].data;
    if (pipe.size() == 1 && pipe[0].age == 0) return pipe[0].data;
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_rsp_data();
    return dp_fn(pipe[0].data, pipe[0].chk, pipe[0].en);
  endfunction

  // Model update on each rising edge
  always @(posedge clk) begin
    int g;
    bit acc;
    bit inc;
    item_t it;
    if (rst) begin
      pipe.delete();
      m_rr = 0;
      m_cnt = 0;
    end else begin
      g = m_grant();
      acc = (g >= 0) && m_open();
      if (m_rsp_valid() && bus.rsp_ready) void'(pipe.pop_front());
      foreach (pipe[k]) pipe[k].age = pipe[k].age + 1;
      if (acc) begin
        it.data = bus.req_data[g*32 +: 32];
        it.chk = bus.req_check[g*8 +: 8];
        it.en = bus.req_chk_en[g];
        it.idx = g;
        it.age = 0;
        it.counted = 0;
        pipe.push_back(it);
        m_rr = (g + 1) % NREQ;
      end
      inc = 0;
      if (m_rsp_valid() && !pipe[0].counted) begin
        pipe[0].counted = 1;
        inc = (m_rsp_data() != pipe[0].data);
      end
      if (clr_count) m_cnt = 0;
      else if (inc && m_cnt < CMAX) m_cnt = m_cnt + 1;
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    clr_count = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++; if (dp_id !== 32'h0) $display("FAIL reset_dp_id got=%h exp=0", dp_id); else pass_cnt++;
    total_cnt++; if (dp_ic !== 8'h0) $display("FAIL reset_dp_ic got=%h exp=0", dp_ic); else pass_cnt++;
    total_cnt++; if (dp_r !== 1'b0) $display("FAIL reset_dp_r got=%b exp=0", dp_r); else pass_cnt++;
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (bus.rsp_data !== 32'h0) $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); else pass_cnt++;
    total_cnt++; if (bus.rsp_id !== '0) $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); else pass_cnt++;
    total_cnt++; if (bus.rsp_corrected !== 1'b0) $display("FAIL reset_rsp_corrected got=%b exp=0", bus.rsp_corrected); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== '0) $display("FAIL reset_req_ready got=%b exp=0", bus.req_ready); else pass_cnt++;
    total_cnt++; if (corr_count !== '0) $display("FAIL reset_corr_count got=%0d exp=0", corr_count); else pass_cnt++;
  endtask

  task automatic test_single();
    int idx_t[3] = '{0, 1, 2};
    logic [31:0] dat_t[3] = '{32'h0000_0000, 32'h0000_0001, 32'h0001_0000};
    logic en_t[3] = '{1'b0, 1'b0, 1'b1};
    logic cor_t[3] = '{1'b0, 1'b1, 1'b1};
    int cnt_t[3] = '{0, 1, 2};
    bus.rsp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      bus.req_valid = '0;
      bus.req_valid[idx_t[t]] = 1'b1;
      bus.req_data[idx_t[t]*32 +: 32] = dat_t[t];
      bus.req_check[idx_t[t]*8 +: 8] = 8'h00;
      bus.req_chk_en[idx_t[t]] = en_t[t];
      #1;
      total_cnt++; if (bus.req_ready !== NREQ'(1) << idx_t[t]) $display("FAIL single_req_ready t=%0d got=%b", t, bus.req_ready); else pass_cnt++;
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_early_rsp t=%0d got=%b exp=0", t, bus.rsp_valid); else pass_cnt++;
      @(negedge clk);
      #1;
      total_cnt++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_rsp_valid t=%0d got=%b exp=1", t, bus.rsp_valid); else pass_cnt++;
      total_cnt++; if (bus.rsp_data !== 32'h0) $display("FAIL single_rsp_data t=%0d got=%h exp=0", t, bus.rsp_data); else pass_cnt++;
      total_cnt++; if (bus.rsp_id !== IDX_W'(idx_t[t])) $display("FAIL single_rsp_id t=%0d got=%0d exp=%0d", t, bus.rsp_id, idx_t[t]); else pass_cnt++;
      total_cnt++; if (bus.rsp_corrected !== cor_t[t]) $display("FAIL single_rsp_corrected t=%0d got=%b exp=%b", t, bus.rsp_corrected, cor_t[t]); else pass_cnt++;
      total_cnt++; if (corr_count !== CNT_W'(cnt_t[t])) $display("FAIL single_corr_count t=%0d got=%0d exp=%0d", t, corr_count, cnt_t[t]); else pass_cnt++;
    end
  endtask

  task automatic test_round_robin();
    reset_dut();
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      bus.req_valid = '1;
      for (int i = 0; i < NREQ; i++) begin
        bus.req_data[i*32 +: 32] = $urandom();
        bus.req_check[i*8 +: 8] = 8'($urandom());
        bus.req_chk_en[i] = 1'($urandom_range(0, 1));
      end
      #1;
      total_cnt++; if (bus.req_ready !== NREQ'(1) << (n % NREQ)) $display("FAIL rr_grant n=%0d got=%b", n, bus.req_ready); else pass_cnt++;
      if (n >= 2) begin
        total_cnt++; if (bus.rsp_valid !== 1'b1) $display("FAIL rr_rsp_valid n=%0d got=%b exp=1", n, bus.rsp_valid); else pass_cnt++;
        total_cnt++; if (bus.rsp_id !== IDX_W'((n - 2) % NREQ)) $display("FAIL rr_rsp_id n=%0d got=%0d exp=%0d", n, bus.rsp_id, (n - 2) % NREQ); else pass_cnt++;
        total_cnt++; if (bus.rsp_data !== m_rsp_data()) $display("FAIL rr_rsp_data n=%0d got=%h exp=%h", n, bus.rsp_data, m_rsp_data()); else pass_cnt++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] snap;
    snap = '0;
    reset_dut();
    for (int n = 0; n < 11; n++) begin
      @(negedge clk);
      bus.req_valid = (n < 8) ? '1 : '0;
      bus.rsp_ready = (n < 3 || n >= 8);
      #1;
      if (n < 3) begin
        total_cnt++; if (bus.req_ready !== NREQ'(1) << n) $display("FAIL bp_grant n=%0d got=%b", n, bus.req_ready); else pass_cnt++;
      end else if (n < 8) begin
        if (n == 3) snap = bus.rsp_data;
        total_cnt++; if (bus.req_ready !== '0) $display("FAIL bp_req_ready n=%0d got=%b exp=0", n, bus.req_ready); else pass_cnt++;
        total_cnt++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_rsp_valid n=%0d got=%b exp=1", n, bus.rsp_valid); else pass_cnt++;
        total_cnt++; if (bus.rsp_id !== IDX_W'(1)) $display("FAIL bp_rsp_id n=%0d got=%0d exp=1", n, bus.rsp_id); else pass_cnt++;
        total_cnt++; if (bus.rsp_data !== snap) $display("FAIL bp_rsp_stable n=%0d got=%h exp=%h", n, bus.rsp_data, snap); else pass_cnt++;
      end else if (n < 10) begin
        total_cnt++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_drain_valid n=%0d got=%b exp=1", n, bus.rsp_valid); else pass_cnt++;
        total_cnt++; if (bus.rsp_id !== IDX_W'(n - 7)) $display("FAIL bp_drain_id n=%0d got=%0d exp=%0d", n, bus.rsp_id, n - 7); else pass_cnt++;
        total_cnt++; if (bus.rsp_data !== m_rsp_data()) $display("FAIL bp_drain_data n=%0d got=%h exp=%h", n, bus.rsp_data, m_rsp_data()); else pass_cnt++;
      end else begin
        total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL bp_drained n=%0d got=%b exp=0", n, bus.rsp_valid); else pass_cnt++;
      end
    end
  endtask

  task automatic test_saturation();
    int exp_c;
    reset_dut();
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      bus.req_valid = '0;
      bus.req_valid[0] = (n <= 5);
      bus.req_data[31:0] = 32'h1 << n;
      bus.req_chk_en[0] = 1'b0;
      clr_count = (n == 6);
      #1;
      if (n >= 2) begin
        exp_c = (n >= 7) ? 0 : ((n - 1 > CMAX) ? CMAX : n - 1);
        total_cnt++; if (corr_count !== CNT_W'(exp_c)) $display("FAIL sat_corr_count n=%0d got=%0d exp=%0d", n, corr_count, exp_c); else pass_cnt++;
      end
    end
    clr_count = 1'b0;
  endtask

  task automatic test_reset_midflight();
    reset_dut();
    bus.rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      bus.req_valid = '1;
      #1;
    end
    total_cnt++; if (bus.rsp_valid !== 1'b1) $display("FAIL mid_full_rsp got=%b exp=1", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== '0) $display("FAIL mid_full_ready got=%b exp=0", bus.req_ready); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL mid_rsp_valid got=%b exp=0", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (dp_id !== 32'h0) $display("FAIL mid_dp_id got=%h exp=0", dp_id); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== NREQ'(1)) $display("FAIL mid_grant got=%b exp=0001", bus.req_ready); else pass_cnt++;
  endtask

  task automatic test_random();
    reset_dut();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 63) == 0);
      clr_count = ($urandom_range(0, 15) == 0);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        bus.req_valid[i] = 1'($urandom_range(0, 1));
        bus.req_data[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
        bus.req_check[i*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'h0 : 8'($urandom());
        bus.req_chk_en[i] = 1'($urandom_range(0, 1));
      end
      #1;
      total_cnt++; if (bus.req_ready !== m_ready()) $display("FAIL rand_req_ready n=%0d got=%b exp=%b", n, bus.req_ready, m_ready()); else pass_cnt++;
      total_cnt++; if (bus.rsp_valid !== m_rsp_valid()) $display("FAIL rand_rsp_valid n=%0d got=%b exp=%b", n, bus.rsp_valid, m_rsp_valid()); else pass_cnt++;
      total_cnt++; if (dp_id !== m_dp_id()) $display("FAIL rand_dp_id n=%0d got=%h exp=%h", n, dp_id, m_dp_id()); else pass_cnt++;
      total_cnt++; if (corr_count !== CNT_W'(m_cnt)) $display("FAIL rand_corr_count n=%0d got=%0d exp=%0d", n, corr_count, m_cnt); else pass_cnt++;
      if (m_rsp_valid()) begin
        total_cnt++; if (bus.rsp_data !== m_rsp_data()) $display("FAIL rand_rsp_data n=%0d got=%h exp=%h", n, bus.rsp_data, m_rsp_data()); else pass_cnt++;
        total_cnt++; if (bus.rsp_id !== IDX_W'(pipe[0].idx)) $display("FAIL rand_rsp_id n=%0d got=%0d exp=%0d", n, bus.rsp_id, pipe[0].idx); else pass_cnt++;
        total_cnt++; if (bus.rsp_corrected !== (m_rsp_data() != pipe[0].data)) $display("FAIL rand_rsp_corrected n=%0d got=%b", n, bus.rsp_corrected); else pass_cnt++;
      end
    end
    rst = 1'b0;
    clr_count = 1'b0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_check = '0;
    bus.req_chk_en = '0;
    bus.rsp_ready = 1'b0;
    clr_count = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_saturation();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sec32_share_arbiter.md
Name: sec32_share_arbiter

Overview:
- Shares one 32-bit single-error-correcting decode datapath among NREQ requesters.
- The datapath is the combinational syndrome/correction block with 32 data inputs, 8 check inputs, a check-enable input R and 32 corrected outputs.
- This block owns the round-robin grant, registers the datapath operands, captures the corrected word into a response stage, and maintains a saturating corrected-word counter.
- It sits between the memory-read clients and the shared datapath instance.

Parameters:
NREQ, 4, number of requesters (2..8)
IDX_W, 2, requester index width; must equal clog2(NREQ)
CNT_W, 16, width of the corrected-word counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept; at most one bit high per cycle
req_data  input  NREQ*32  word i in bits [32i+31:32i]; bit 32i+k maps to datapath ID[k]
req_check  input  NREQ*8  check byte i in bits [8i+7:8i]; bit 8i+k maps to IC[k]
req_chk_en  input  NREQ  drives datapath R for that request
dp_id  output  32  to datapath ID; bit k = ID[k]
dp_ic  output  8  to datapath IC; bit k = IC[k]
dp_r  output  1  to datapath R
dp_od  input  32  from datapath OD; bit k = OD[k]
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_data  output  32  corrected word, same bit order as dp_od
rsp_id  output  IDX_W  index of the originating requester
rsp_corrected  output  1  1 when rsp_data differs from the submitted word
corr_count  output  CNT_W  number of corrected words, saturating
clr_count  input  1  synchronous counter clear

Behaviour:
- Two-stage pipeline: S1 is the operand register driving dp_*; S2 is the response register. Each stage has a valid bit.
- Reset: S1 and S2 valid cleared, rr pointer = 0, corr_count = 0. Outputs after reset: dp_id = 0, dp_ic = 0, dp_r = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_corrected = 0, req_ready = 0.
- Reset asserted mid-operation discards S1/S2 contents. No response is issued for discarded requests.
- Grant (combinational): the first i with req_valid[i] set, searching from rr pointer upward with wrap at NREQ-1 -> 0. req_ready may depend on req_valid.
- s2_free = ~S2.valid | rsp_ready.
- s1_adv = S1.valid & s2_free.
- req_ready[g] = (~S1.valid | s1_adv) for the granted g; all other bits are 0.
- Accept = req_valid[g] & req_ready[g]. On accept, S1 loads the word, check byte, chk_en and index g, and rr pointer becomes (g+1) mod NREQ. With no accept, rr pointer holds.
- While S1.valid is 0, dp_id/dp_ic/dp_r are driven to 0.
- On s1_adv, S2 loads rsp_data = dp_od, rsp_id = S1.index, and rsp_corrected = (dp_od != dp_id).
- Latency: handshake in cycle c -> rsp_valid high in cycle c+2. Full throughput is 1 request per cycle while rsp_ready stays high.
- Response handshake: rsp_valid & rsp_ready retires S2. While rsp_valid is 1 and rsp_ready is 0, all rsp_* outputs hold stable and S1 stalls. req_ready goes to 0 once S1 is also full.
- Same-cycle S2 retire and S1 advance are legal. S2 reloads with no bubble.
- corr_count increments by 1 on s1_adv with rsp_corrected-to-be = 1. It saturates at all-ones.
- clr_count sets corr_count to 0 and wins over a same-cycle increment.
- Requests with no valid are never granted. A requester dropping req_valid before its accept is legal.

Test Plan:
- Reset, then req 0: data 32'h0000_0000, chk_en=0 -> cycle+2: rsp_valid=1, rsp_data=0, rsp_id=0, rsp_corrected=0, corr_count=0.
- Req 1: data 32'h0000_0001 (ID[0] flipped), chk_en=0 -> rsp_data=32'h0, rsp_corrected=1, corr_count=1.
- Req 2: data 32'h0001_0000 (ID[16] flipped), chk_en=1, check=8'h00 -> rsp_data=0, rsp_corrected=1, rsp_id=2.
- All four requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,…; one rsp per cycle with rsp_id in the same order.
- rsp_ready held 0 for 5 cycles with traffic pending -> rsp_* stable, req_ready=0 after S1 fills. Release -> no loss or duplication, order preserved.
- CNT_W=2: 5 corrected words -> corr_count 1,2,3,3,3. clr_count pulsed together with a corrected word -> 0.
- rst asserted with S1 and S2 full -> next cycle rsp_valid=0, dp_id=0, and the next grant goes to requester 0.
